// File: rtl/prog_loader.sv
// UART program loader: receives an 0xA5-framed, checksummed program over rx
// and writes it as 16-bit words into the CPU instruction RAM.
module prog_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        boot_mode,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TMO  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int TW   = $clog2(TMO + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {F_IDLE, F_LEN, F_LO, F_HI, F_CSUM} f_state_t;

    rx_state_t       rx_state;
    logic            rx_s1, rx_s2, rx_d;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            byte_valid, frame_err;

    f_state_t        f_state;
    logic [7:0]      sum, lo;
    logic [8:0]      words_left;
    logic [10:0]     addr_next;
    logic [TW-1:0]   tmo_cnt;

    // Byte receiver; rx_d gives the previous synchronized level for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!boot_mode) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_d && !rx_s2) begin
                            rx_state <= RX_START;
                            clk_cnt  <= '0;
                        end
                    end
                    RX_START: begin
                        if (clk_cnt == CW'(HALF - 1)) begin
                            clk_cnt  <= '0;
                            bit_idx  <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                            clk_cnt <= '0;
                            rx_byte <= {rx_s2, rx_byte[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                            clk_cnt    <= '0;
                            byte_valid <= rx_s2;
                            frame_err  <= !rx_s2;
                            rx_state   <= RX_IDLE;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // Frame FSM; priority: boot_mode off, framing error, byte strobe, then timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state    <= F_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sum        <= '0;
            lo         <= '0;
            words_left <= '0;
            addr_next  <= '0;
            tmo_cnt    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (!boot_mode) begin
                f_state <= F_IDLE;
                busy    <= 1'b0;
                tmo_cnt <= '0;
            end else if (frame_err && f_state != F_IDLE) begin
                f_state <= F_IDLE;
                busy    <= 1'b0;
                err     <= 1'b1;
            end else if (byte_valid) begin
                tmo_cnt <= '0;
                case (f_state)
                    F_IDLE: begin
                        if (rx_byte == 8'hA5) begin
                            f_state   <= F_LEN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            sum       <= '0;
                            addr_next <= '0;
                        end
                    end
                    F_LEN: begin
                        words_left <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                        sum        <= rx_byte;
                        f_state    <= F_LO;
                    end
                    F_LO: begin
                        lo      <= rx_byte;
                        sum     <= sum + rx_byte;
                        f_state <= F_HI;
                    end
                    F_HI: begin
                        sum        <= sum + rx_byte;
                        mem_we     <= 1'b1;
                        mem_addr   <= addr_next;
                        mem_wdata  <= {rx_byte, lo};
                        addr_next  <= addr_next + 11'd2;
                        words_left <= words_left - 1'b1;
                        f_state    <= (words_left == 9'd1) ? F_CSUM : F_LO;
                    end
                    F_CSUM: begin
                        if (8'(sum + rx_byte) == 8'h00) done <= 1'b1;
                        else                            err  <= 1'b1;
                        busy    <= 1'b0;
                        f_state <= F_IDLE;
                    end
                    default: f_state <= F_IDLE;
                endcase
            end else if (f_state != F_IDLE) begin
                if (tmo_cnt == TW'(TMO - 1)) begin
                    f_state <= F_IDLE;
                    busy    <= 1'b0;
                    err     <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end
endmodule
